// File: rtl/div_pkg.sv
// Shared definitions for the sequential radix-2 signed divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 16;
  localparam int unsigned DIV_ITER  = DIV_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StAbs,
    StIter,
    StFix,
    StDone
  } div_state_t;

  // Quotient reported for a divide by zero.
  localparam logic [DIV_WIDTH-1:0] DIV_Q_DBZ = '1;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor
// magnitude and keep the difference only if it did not go negative.
module div_restore_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   prem_in,
  input  logic             qbit_in,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH:0]   prem_out,
  output logic             qbit_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Partial remainder always stays below dmag, so the top bit of prem_in is never needed.
  always_comb begin
    shifted  = {prem_in[WIDTH-1:0], qbit_in};
    trial    = shifted - {1'b0, dmag};
    qbit_out = ~trial[WIDTH];
    prem_out = qbit_out ? trial : shifted;
  end

endmodule

// File: rtl/seq_div_signed16_r2.sv
// Sequential radix-2 signed divider, one quotient bit per cycle.
// Optional build macro DIV_OVF_SAT_EN: saturate -2^(WIDTH-1) / -1 to the largest positive
// quotient and raise ovf; otherwise the quotient wraps and ovf stays 0.
module seq_div_signed16_r2
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             ovf
);

  localparam int unsigned ITER = WIDTH;
  localparam int unsigned CntW = $clog2(ITER);

  div_state_t       state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             dbz_q, dbz_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] dmag_q, dmag_d, qmag_q, qmag_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [WIDTH:0]   step_prem;
  logic             step_qbit;
  logic             q_neg;

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .prem_in (prem_q),
    .qbit_in (qmag_q[WIDTH-1]),
    .dmag    (dmag_q),
    .prem_out(step_prem),
    .qbit_out(step_qbit)
  );

  assign q_neg = dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];

  // Next-state and registered-output logic for the divide sequence.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = done_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    dmag_d  = dmag_q;
    qmag_d  = qmag_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          busy_d  = 1'b1;
          state_d = (divisor == '0) ? StDone : StAbs;
        end
      end
      StAbs: begin
        // Magnitude of the most negative value is 2^(WIDTH-1), still representable unsigned.
        qmag_d  = dvd_q[WIDTH-1] ? -dvd_q : dvd_q;
        dmag_d  = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
        prem_d  = '0;
        cnt_d   = CntW'(ITER - 1);
        state_d = StIter;
      end
      StIter: begin
        prem_d = step_prem;
        qmag_d = {qmag_q[WIDTH-2:0], step_qbit};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = StFix;
        end
      end
      StFix: begin
        quot_d = q_neg ? -qmag_q : qmag_q;
        rem_d  = dvd_q[WIDTH-1] ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
        dbz_d  = 1'b0;
        ovf_d  = 1'b0;
`ifdef DIV_OVF_SAT_EN
        // A non-negated magnitude with the top bit set only arises from min / -1.
        if (!q_neg && qmag_q[WIDTH-1]) begin
          quot_d = {1'b0, {(WIDTH-1){1'b1}}};
          ovf_d  = 1'b1;
        end
`endif
        done_d  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (done_q) begin
          done_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          // Divide-by-zero arrives here straight from idle; load its results now.
          quot_d = DIV_Q_DBZ;
          rem_d  = dvd_q;
          dbz_d  = 1'b1;
          ovf_d  = 1'b0;
          done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      dmag_q  <= '0;
      qmag_q  <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      dmag_q  <= dmag_d;
      qmag_q  <= qmag_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign ovf         = ovf_q;

endmodule
